// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Fetch stage. Generates the fetch PC, requests 16-bit words over
//            a req/ack handshake and splits each word into opcode and three
//            4-bit fields for the IF/ID buffer. Honours the decode hazard
//            stall and redirects on taken branches.
// Options  : FETCH_SKID_EN - adds a one-entry skid buffer (HOLD state) so a
//            response that lands during a stall is kept instead of refetched.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hazard,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [3:0]  opcode,
   output logic [3:0]  one,
   output logic [3:0]  two,
   output logic [3:0]  three,
   output logic [15:0] PC,
   output logic        valid
);

`ifdef FETCH_SKID_EN
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DRAIN = 2'd2} state_t;
`endif

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_pc;
   logic [15:0] w_pc_nxt;
   logic [15:0] r_drain_addr;
   logic [15:0] w_drain_addr_nxt;
   logic [15:0] r_instr;
   logic [15:0] r_pc_out;
   logic        r_valid;
   logic        w_load_mem;
   logic        w_clr_valid;
`ifdef FETCH_SKID_EN
   logic [15:0] r_skid_word;
   logic [15:0] r_skid_pc;
   logic        w_cap_skid;
   logic        w_load_skid;
`endif

   // A request is live in REQ and DRAIN; DRAIN keeps the pre-branch address
   assign imem_req  = (r_state == REQ) || (r_state == DRAIN);
   assign imem_addr = (r_state == DRAIN) ? r_drain_addr : r_pc;

   assign opcode = r_instr[15:12];
   assign one    = r_instr[11:8];
   assign two    = r_instr[7:4];
   assign three  = r_instr[3:0];
   assign PC     = r_pc_out;
   assign valid  = r_valid;

   // State, fetch PC and drain address registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_drain_addr <= 16'h0000;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_drain_addr <= w_drain_addr_nxt;
      end
   end

   // Next-state logic; a branch overrides whatever the current state decided
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_drain_addr_nxt = r_drain_addr;
      w_load_mem       = 1'b0;
      w_clr_valid      = 1'b0;
`ifdef FETCH_SKID_EN
      w_cap_skid       = 1'b0;
      w_load_skid      = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (!hazard) w_state_nxt = REQ;
         end
         REQ: begin
            if (imem_ack) begin
               if (!hazard) begin
                  w_load_mem = 1'b1;
                  w_pc_nxt   = r_pc + PC_STEP;
               end else begin
`ifdef FETCH_SKID_EN
                  w_cap_skid  = 1'b1;
                  w_pc_nxt    = r_pc + PC_STEP;
                  w_state_nxt = HOLD;
`else
                  w_state_nxt = IDLE;
`endif
               end
            end
         end
         DRAIN: begin
            if (imem_ack) w_state_nxt = hazard ? IDLE : REQ;
         end
`ifdef FETCH_SKID_EN
         HOLD: begin
            if (!hazard) begin
               w_load_skid = 1'b1;
               w_state_nxt = REQ;
            end
         end
`endif
         default: w_state_nxt = IDLE;
      endcase

      if (branch_taken) begin
         w_pc_nxt    = branch_target;
         w_clr_valid = 1'b1;
         w_load_mem  = 1'b0;
`ifdef FETCH_SKID_EN
         w_cap_skid  = 1'b0;
         w_load_skid = 1'b0;
`endif
         if (imem_req && !imem_ack) begin
            // Old request must complete before the target can be issued
            w_state_nxt = DRAIN;
            if (r_state == REQ) w_drain_addr_nxt = r_pc;
         end else begin
            w_state_nxt = hazard ? IDLE : REQ;
         end
      end
   end

   // IF/ID output registers: load on accepted response, clear valid on branch
   always_ff @(posedge clk) begin
      if (reset) begin
         r_instr  <= 16'h0000;
         r_pc_out <= 16'h0000;
         r_valid  <= 1'b0;
      end else if (w_clr_valid) begin
         r_valid  <= 1'b0;
      end else if (w_load_mem) begin
         r_instr  <= imem_rdata;
         r_pc_out <= r_pc;
         r_valid  <= 1'b1;
      end
`ifdef FETCH_SKID_EN
      else if (w_load_skid) begin
         r_instr  <= r_skid_word;
         r_pc_out <= r_skid_pc;
         r_valid  <= 1'b1;
      end
`endif
   end

`ifdef FETCH_SKID_EN
   // Skid entry: holds a response that arrived while decode was stalled
   always_ff @(posedge clk) begin
      if (reset || branch_taken) begin
         r_skid_word <= 16'h0000;
         r_skid_pc   <= 16'h0000;
      end else if (w_cap_skid) begin
         r_skid_word <= imem_rdata;
         r_skid_pc   <= r_pc;
      end
   end
`endif

endmodule
`default_nettype wire
